golden_nonce_checker: RTL and testbench
=======================================

Name: golden_nonce_checker

Overview:
- Downstream consumer of the SHA-256 transform's 256-bit hash output.
- Tags each hash with its nonce and discards hashes still in flight from the previous job after a work load.
- Tests each hash against a difficulty target and queues winning ("golden") nonces in a small FIFO.
- Drains the FIFO to the host-facing serial transmitter over a valid/ready handshake.

Parameters:
- DISCARD, 4, number of hash_valid beats dropped after each work_load; equals the transform pipeline depth in hashes.
- DEPTH, 4, golden-nonce FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- work_load  in  1  single-cycle pulse; new job starts.
- nonce_base  in  32  first nonce of the new job; sampled when work_load=1.
- target  in  32  compared against hash word 6; may change at any time and is sampled per hash.
- hash_valid  in  1  one-cycle strobe; hash_in is valid.
- hash_in  in  256  transform output; word n occupies bits 32n+31:32n.
- gn_valid  out  1  FIFO non-empty.
- gn_ready  in  1  consumer accepts the head entry.
- gn_nonce  out  32  head of FIFO.
- gn_overflow  out  1  sticky flag; a golden nonce was dropped because the FIFO was full.
- busy  out  1  high in PRIME or RUN.

Behaviour:
- Reset (async assert, sync deassert on first clk after release):
  - state=IDLE, nonce_cnt=0, discard_cnt=0, FIFO empty.
  - gn_valid=0, gn_nonce=0, gn_overflow=0, busy=0.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: hash_valid ignored. work_load -> PRIME.
  - PRIME: each hash_valid decrements discard_cnt and the hash is dropped (no nonce increment). When the last discard beat arrives (discard_cnt==1 with hash_valid), go to RUN. If DISCARD=0, work_load goes directly to RUN.
  - RUN: each hash_valid is checked against nonce_cnt, then nonce_cnt increments. Stay in RUN until work_load.
- work_load in any state:
  - nonce_cnt<=nonce_base, discard_cnt<=DISCARD, FIFO flushed (pointers reset, gn_valid=0 next cycle), gn_overflow cleared.
  - A hash_valid in the same cycle is dropped.
  - work_load has priority over every other event.
- Golden test: golden = (hash_in[255:224]==0) && (hash_in[223:192] <= target).
  - The word-6 comparison is unsigned.
- Push: in RUN, hash_valid && golden writes nonce_cnt (the pre-increment value) into the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the entry is dropped and gn_overflow<=1.
  - If the FIFO is full and a pop occurs in the same cycle, the push succeeds.
- Pop: gn_valid && gn_ready advances the read pointer.
  - Simultaneous push and pop on an empty FIFO: the pop is not allowed (gn_valid=0), the push succeeds, and gn_valid=1 next cycle.
- Latency: golden hash at cycle N -> gn_valid=1 and gn_nonce correct at cycle N+1 (registered FIFO, show-ahead head).
- gn_nonce holds its value while gn_valid=0 and gn_ready=0. gn_nonce is stable while gn_valid=1 and gn_ready=0.
- nonce_cnt wraps 0xFFFFFFFF -> 0x00000000 silently; the FSM stays in RUN.
- busy is a registered decode of state.

Optional Feature:
- Macro GOLDEN_NONCE_STATS_EN.
- When defined, adds two outputs:
  - hash_count[31:0]: counts hashes tested in RUN.
  - golden_count[31:0]: counts golden hits, including dropped ones.
  - Both reset to 0, clear on work_load, and wrap silently.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, PRIME=2'd1, RUN=2'd2) and the word-index helper for 32-bit slices of 256-bit buses.
- One sub-module: nonce_fifo, a synchronous show-ahead FIFO (DEPTH x 32, flush input, full/empty flags).
- The FSM, nonce counter and golden comparator stay in the top module.

Test Plan:
- Reset mid-run with FIFO holding 2 entries, rst_n low for 1 cycle -> gn_valid=0, busy=0, gn_overflow=0 immediately, asynchronously.
- work_load with nonce_base=0x00001000, DISCARD=4, then 6 hash_valid beats, all golden (word7=0, word6=0, target=0) -> the first 4 are dropped; FIFO receives 0x00001000 then 0x00001001; gn_valid rises 1 cycle after the 5th beat.
- RUN with target=0x0000FFFF: word7=0, word6=0x00010000 -> not pushed; word7=0, word6=0x0000FFFF -> pushed; word7=1, word6=0 -> not pushed.
- gn_ready=0 and 5 golden hashes with DEPTH=4 -> 4 entries retained in order, gn_overflow=1; then gn_ready=1 drains them in 4 cycles; gn_overflow stays 1.
- FIFO full with push and pop in the same cycle -> no overflow, occupancy stays 4, and the new nonce appears last in order.
- nonce_base=0xFFFFFFFF, DISCARD=0, two golden hashes -> queued nonces 0xFFFFFFFF then 0x00000000; work_load in the same cycle as a third hash_valid -> FIFO empty next cycle and the third hash is not queued.

Source files
------------

// File: rtl/golden_nonce_checker_pkg.sv
// Shared definitions for the golden-nonce checker: FSM encoding and a word-slice helper.
package golden_nonce_checker_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPrime = 2'd1,
      StRun   = 2'd2
   } state_e;

   localparam int unsigned WordW = 32;

   // Extract 32-bit word idx from a 256-bit bus (word n at bits 32n+31:32n).
   function automatic logic [WordW-1:0] hash_word(input logic [255:0] bus,
                                                  input int unsigned idx);
      return bus[idx*WordW +: WordW];
   endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous show-ahead FIFO for golden nonces. The head is held in a register so the output
// only changes when a new head is presented, and it holds its last value while empty.
module nonce_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        push,
   input  logic [31:0] din,
   input  logic        pop,
   output logic [31:0] dout,
   output logic        full,
   output logic        empty
);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [AW:0]   count_q;
   logic [31:0]   head_q;
   logic          push_eff, pop_eff;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign pop_eff  = pop && !empty;
   // A full FIFO still accepts a push when an entry leaves in the same cycle.
   assign push_eff = push && (!full || pop_eff);
   assign rd_next  = rd_ptr_q + AW'(1);
   assign dout     = head_q;

   // Storage array write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push_eff && !flush) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointers and occupancy; flush empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_eff)  rd_ptr_q <= rd_next;
         if (push_eff && !pop_eff)      count_q <= count_q + (AW+1)'(1);
         else if (pop_eff && !push_eff) count_q <= count_q - (AW+1)'(1);
      end
   end

   // Show-ahead head register: load the next entry on pop, or din when pushing into empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
      end else if (!flush) begin
         if (pop_eff) begin
            if (count_q > (AW+1)'(1)) head_q <= mem_q[rd_next];
            else if (push_eff)        head_q <= din;
         end else if (push_eff && empty) begin
            head_q <= din;
         end
      end
   end

endmodule

// File: rtl/golden_nonce_checker.sv
// Golden-nonce checker: tags SHA-256 hashes with nonces, drops in-flight hashes after a job load,
// tests each against the difficulty target and queues winners for the host transmitter.
// Optional statistics counters are enabled with GOLDEN_NONCE_STATS_EN.
module golden_nonce_checker
   import golden_nonce_checker_pkg::*;
#(
   parameter int unsigned DISCARD = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned AW      = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         work_load,
   input  logic [31:0]  nonce_base,
   input  logic [31:0]  target,
   input  logic         hash_valid,
   input  logic [255:0] hash_in,
   output logic         gn_valid,
   input  logic         gn_ready,
   output logic [31:0]  gn_nonce,
   output logic         gn_overflow,
   output logic         busy
`ifdef GOLDEN_NONCE_STATS_EN
   ,
   output logic [31:0]  hash_count,
   output logic [31:0]  golden_count
`endif
);

   // Extra headroom keeps the width non-zero when DISCARD is 0.
   localparam int unsigned DW = $clog2(DISCARD + 2);

   state_e        state_q, state_d;
   logic [31:0]   nonce_cnt_q;
   logic [DW-1:0] discard_cnt_q;
   logic          overflow_q;
   logic          busy_q;
   logic          golden, hash_ok, push, pop, fifo_full, fifo_empty;
   logic          unused_low;

   assign unused_low = ^hash_in[191:0];

   assign golden  = (hash_word(hash_in, 7) == 32'd0) && (hash_word(hash_in, 6) <= target);
   // work_load wins over any hash arriving in the same cycle.
   assign hash_ok = (state_q == StRun) && hash_valid && !work_load;
   assign push    = hash_ok && golden;
   assign pop     = gn_valid && gn_ready && !work_load;

   assign gn_valid    = !fifo_empty;
   assign gn_overflow = overflow_q;
   assign busy        = busy_q;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (work_load) begin
         state_d = (DISCARD == 0) ? StRun : StPrime;
      end else begin
         case (state_q)
            StIdle:  state_d = StIdle;
            StPrime: if (hash_valid && discard_cnt_q == DW'(1)) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
         endcase
      end
   end

   // State register with registered busy decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StIdle);
      end
   end

   // Nonce and discard counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nonce_cnt_q   <= '0;
         discard_cnt_q <= '0;
      end else if (work_load) begin
         nonce_cnt_q   <= nonce_base;
         discard_cnt_q <= DW'(DISCARD);
      end else if (state_q == StPrime && hash_valid) begin
         discard_cnt_q <= discard_cnt_q - DW'(1);
      end else if (hash_ok) begin
         nonce_cnt_q <= nonce_cnt_q + 32'd1;
      end
   end

   // Sticky overflow: a golden nonce met a full FIFO with nothing leaving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (work_load) begin
         overflow_q <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         overflow_q <= 1'b1;
      end
   end

`ifdef GOLDEN_NONCE_STATS_EN
   logic [31:0] hash_count_q, golden_count_q;

   assign hash_count   = hash_count_q;
   assign golden_count = golden_count_q;

   // Statistics: hashes tested in RUN and golden hits including dropped ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hash_count_q   <= '0;
         golden_count_q <= '0;
      end else if (work_load) begin
         hash_count_q   <= '0;
         golden_count_q <= '0;
      end else begin
         if (hash_ok) hash_count_q   <= hash_count_q + 32'd1;
         if (push)    golden_count_q <= golden_count_q + 32'd1;
      end
   end
`endif

   nonce_fifo #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(work_load),
      .push (push),
      .din  (nonce_cnt_q),
      .pop  (pop),
      .dout (gn_nonce),
      .full (fifo_full),
      .empty(fifo_empty)
   );

endmodule

// File: tb/tb_golden_nonce_checker.sv
// Randomized self-checking bench for golden_nonce_checker against a queue-based reference model.
module tb_golden_nonce_checker;

   localparam int DISC = 4;
   localparam int DEP  = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         work_load;
   logic [31:0]  nonce_base;
   logic [31:0]  target;
   logic         hash_valid;
   logic [255:0] hash_in;
   logic         gn_valid;
   logic         gn_ready;
   logic [31:0]  gn_nonce;
   logic         gn_overflow;
   logic         busy;
`ifdef GOLDEN_NONCE_STATS_EN
   logic [31:0]  hash_count, golden_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: 0=idle 1=prime 2=run.
   int          m_mode;
   int          m_disc;
   logic [31:0] m_nonce;
   logic        m_ovf;
   logic [31:0] m_last;
   logic [31:0] m_q[$];
   logic [31:0] m_hcnt, m_gcnt;

   always #5 clk = ~clk;

   golden_nonce_checker #(
      .DISCARD(DISC),
      .DEPTH  (DEP),
      .AW     (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .work_load  (work_load),
      .nonce_base (nonce_base),
      .target     (target),
      .hash_valid (hash_valid),
      .hash_in    (hash_in),
      .gn_valid   (gn_valid),
      .gn_ready   (gn_ready),
      .gn_nonce   (gn_nonce),
      .gn_overflow(gn_overflow),
      .busy       (busy)
`ifdef GOLDEN_NONCE_STATS_EN
      ,
      .hash_count  (hash_count),
      .golden_count(golden_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [255:0] mk_hash(input logic [31:0] w7, input logic [31:0] w6);
      logic [255:0] h;
      h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      h[255:224] = w7;
      h[223:192] = w6;
      return h;
   endfunction

   task automatic model_reset();
      m_mode  = 0;
      m_disc  = 0;
      m_nonce = 0;
      m_ovf   = 0;
      m_last  = 0;
      m_hcnt  = 0;
      m_gcnt  = 0;
      m_q.delete();
   endtask

   // One clock of the spec rules, applied to the inputs present at the edge.
   task automatic model_step();
      bit pop_ok, gold;
      pop_ok = (m_q.size() != 0) && gn_ready;
      gold   = (hash_in[255:224] == 0) && (hash_in[223:192] <= target);
      if (work_load) begin
         m_q.delete();
         m_ovf   = 0;
         m_nonce = nonce_base;
         m_disc  = DISC;
         m_mode  = (DISC == 0) ? 2 : 1;
         m_hcnt  = 0;
         m_gcnt  = 0;
      end else begin
         if (pop_ok) void'(m_q.pop_front());
         if (hash_valid && m_mode == 1) begin
            m_disc--;
            if (m_disc == 0) m_mode = 2;
         end else if (hash_valid && m_mode == 2) begin
            m_hcnt++;
            if (gold) begin
               m_gcnt++;
               if (m_q.size() < DEP) m_q.push_back(m_nonce);
               else m_ovf = 1;
            end
            m_nonce++;
         end
      end
   endtask

   task automatic compare();
      check("gn_valid", 32'(gn_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("gn_nonce", gn_nonce, m_q[0]);
      else                 check("gn_nonce_hold", gn_nonce, m_last);
      check("gn_overflow", 32'(gn_overflow), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_mode != 0));
`ifdef GOLDEN_NONCE_STATS_EN
      check("hash_count", hash_count, m_hcnt);
      check("golden_count", golden_count, m_gcnt);
`endif
      if (m_q.size() != 0) m_last = m_q[0];
   endtask

   // Advance one cycle: model at posedge, compare at negedge, then clear one-shot inputs.
   task automatic cycle();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      @(negedge clk);
      compare();
      work_load  = 1'b0;
      hash_valid = 1'b0;
   endtask

   task automatic load(input logic [31:0] nb);
      work_load  = 1'b1;
      nonce_base = nb;
      cycle();
   endtask

   task automatic beat(input logic [31:0] w7, input logic [31:0] w6);
      hash_valid = 1'b1;
      hash_in    = mk_hash(w7, w6);
      cycle();
   endtask

   task automatic discards();
      for (int i = 0; i < DISC; i++) beat($urandom, $urandom);
   endtask

   initial begin
      rst_n      = 1'b0;
      work_load  = 1'b0;
      nonce_base = '0;
      target     = '0;
      hash_valid = 1'b0;
      hash_in    = '0;
      gn_ready   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      compare();

      // Job load, 4 dropped beats, then two golden hashes queued.
      target = 32'h0;
      load(32'h0000_1000);
      for (int i = 0; i < DISC; i++) beat(32'h0, 32'h0);
      check("no_push_in_prime", 32'(gn_valid), 32'd0);
      beat(32'h0, 32'h0);
      check("first_golden_latency", 32'(gn_valid), 32'd1);
      check("first_golden_nonce", gn_nonce, 32'h0000_1000);
      beat(32'h0, 32'h0);

      // Target boundary cases.
      target = 32'h0000_FFFF;
      load(32'h0000_2000);
      discards();
      beat(32'h0, 32'h0001_0000);
      beat(32'h0, 32'h0000_FFFF);
      beat(32'h1, 32'h0);
      check("boundary_head", gn_nonce, 32'h0000_2001);
      gn_ready = 1'b1;
      repeat (3) cycle();
      gn_ready = 1'b0;

      // Overflow with FIFO held full, then drain.
      target = 32'h0;
      load(32'h0000_3000);
      discards();
      for (int i = 0; i < 5; i++) beat(32'h0, 32'h0);
      check("overflow_set", 32'(gn_overflow), 32'd1);
      gn_ready = 1'b1;
      repeat (4) cycle();
      check("drained", 32'(gn_valid), 32'd0);
      check("overflow_sticky", 32'(gn_overflow), 32'd1);
      gn_ready = 1'b0;

      // Full FIFO with simultaneous push and pop.
      load(32'h0000_4000);
      discards();
      for (int i = 0; i < 4; i++) beat(32'h0, 32'h0);
      gn_ready = 1'b1;
      beat(32'h0, 32'h0);
      gn_ready = 1'b0;
      check("full_pushpop_no_ovf", 32'(gn_overflow), 32'd0);
      check("full_pushpop_occ", 32'(m_q.size()), 32'd4);
      gn_ready = 1'b1;
      repeat (4) cycle();
      gn_ready = 1'b0;

      // Nonce wrap, then work_load colliding with a hash.
      load(32'hFFFF_FFFF);
      discards();
      beat(32'h0, 32'h0);
      beat(32'h0, 32'h0);
      check("wrap_head", gn_nonce, 32'hFFFF_FFFF);
      work_load  = 1'b1;
      nonce_base = 32'h0000_5000;
      hash_valid = 1'b1;
      hash_in    = mk_hash(32'h0, 32'h0);
      cycle();
      check("load_flush", 32'(gn_valid), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         gn_ready   = ($urandom_range(0, 2) != 0);
         work_load  = ($urandom_range(0, 199) == 0);
         nonce_base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
         if ($urandom_range(0, 3) == 0) target = $urandom;
         hash_valid = ($urandom_range(0, 3) != 0);
         hash_in    = mk_hash(($urandom_range(0, 2) == 0) ? 32'h0 : $urandom,
                              ($urandom_range(0, 4) == 0) ? target : $urandom);
         cycle();
      end

      // Asynchronous reset mid-run with entries queued.
      target   = 32'h0;
      gn_ready = 1'b0;
      load(32'h0000_6000);
      discards();
      beat(32'h0, 32'h0);
      beat(32'h0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_gn_valid", 32'(gn_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(gn_overflow), 32'd0);
      check("rst_nonce", gn_nonce, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      beat(32'h0, 32'h0);
      check("idle_ignores_hash", 32'(gn_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
